// File: rtl/modbus_pkg.sv
// Shared Modbus RTU framing constants and the framer state encoding.
package modbus_pkg;

   localparam logic [15:0] CRC_POLY_DEF = 16'hA001;
   localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;
   localparam int          MAX_LEN_DEF  = 256;
   localparam int          LEN_W_DEF    = 9;

   typedef enum logic [1:0] {
      DATA   = 2'd0,
      CRC_LO = 2'd1,
      CRC_HI = 2'd2
   } state_t;

endpackage

// File: rtl/crc16_byte_update.sv
// Byte-wise CRC-16 (reflected, right-shift) update; purely combinational.
// Shared with the receive-side checker, so it carries no framing knowledge.
module crc16_byte_update
   import modbus_pkg::*;
#(
   parameter logic [15:0] POLY = CRC_POLY_DEF
) (
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_byte,
   output logic [15:0] crc_out
);

   logic [15:0] x;

   always_comb begin
      x = crc_in ^ {8'h00, data_byte};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
      end
      crc_out = x;
   end

endmodule

// File: rtl/modbus_crc_framer.sv
// Modbus RTU TX framer: payload passes through a one-entry output register, then CRC lo/hi are appended.
// Latency 1 cycle in->out; in_ready drops whenever the output register cannot be refilled or CRC is being sent.
module modbus_crc_framer
   import modbus_pkg::*;
#(
   parameter logic [15:0] CRC_POLY = CRC_POLY_DEF,
   parameter logic [15:0] CRC_INIT = CRC_INIT_DEF,
   parameter int          MAX_LEN  = MAX_LEN_DEF,
   parameter int          LEN_W    = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [LEN_W-1:0] frame_len,
   output logic             len_err
);

   state_t             state, state_nxt;
   logic [15:0]        crc, crc_upd;
   logic [LEN_W-1:0]   count, cnt_inc;
   logic               slot_free, accept, forced_end;

   crc16_byte_update #(.POLY(CRC_POLY)) u_crc (
      .crc_in    (crc),
      .data_byte (in_data),
      .crc_out   (crc_upd)
   );

   always_comb begin
      slot_free  = !out_valid || out_ready;
      // Gated by reset so upstream never sees a handshake while the framer is held.
      in_ready   = rst && (state == DATA) && slot_free;
      accept     = in_valid && in_ready;
      cnt_inc    = count + 1'b1;
      forced_end = (cnt_inc == LEN_W'(MAX_LEN - 2));
      state_nxt  = state;
      case (state)
         DATA:    if (accept && (in_last || forced_end)) state_nxt = CRC_LO;
         CRC_LO:  if (slot_free) state_nxt = CRC_HI;
         CRC_HI:  if (slot_free) state_nxt = DATA;
         default: state_nxt = DATA;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= DATA;
         crc       <= CRC_INIT;
         count     <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_len <= '0;
         len_err   <= 1'b0;
      end else begin
         state   <= state_nxt;
         len_err <= 1'b0;
         // Slot drains when consumed and nothing new is loaded below; out_data holds.
         if (slot_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (state)
            DATA: begin
               if (accept) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  crc       <= crc_upd;
                  count     <= cnt_inc;
                  len_err   <= forced_end && !in_last;
               end
            end
            CRC_LO: begin
               if (slot_free) begin
                  out_data  <= crc[7:0];
                  out_valid <= 1'b1;
                  count     <= cnt_inc;
               end
            end
            CRC_HI: begin
               if (slot_free) begin
                  out_data  <= crc[15:8];
                  out_valid <= 1'b1;
                  out_last  <= 1'b1;
                  frame_len <= cnt_inc;
                  crc       <= CRC_INIT;
                  count     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_modbus_crc_framer.sv
// Randomized bench for modbus_crc_framer against a frame-level reference model.
module tb_modbus_crc_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid, in_last, in_ready;
   logic [7:0] out_data;
   logic       out_valid, out_last, out_ready;
   logic [8:0] frame_len;
   logic       len_err;

   modbus_crc_framer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .frame_len (frame_len),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes queued for upstream, and the byte stream the framer must emit.
   logic [7:0]  stim_d[$];
   logic        stim_l[$];
   logic [8:0]  exp_d[$];
   int          exp_flen[$];
   int          exp_lenerr = 0;
   int          obs_lenerr = 0;
   int          m_n = 0;
   logic [15:0] m_crc = 16'hFFFF;

   // Driver-side frame tracking, used to predict when in_ready must stay low.
   int          in_n = 0;
   bit          crc_phase = 0;
   logic [7:0]  tail_lo, tail_hi, prev_out;

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = r >> 1;
         if (fb) r = r ^ 16'hA001;
      end
      return r;
   endfunction

   task automatic push_byte(input logic [7:0] d, input logic last);
      stim_d.push_back(d);
      stim_l.push_back(last);
      exp_d.push_back({1'b0, d});
      m_crc = crc_ref(m_crc, d);
      m_n++;
      if (last || m_n == 254) begin
         if (!last) exp_lenerr++;
         exp_d.push_back({1'b0, m_crc[7:0]});
         exp_d.push_back({1'b1, m_crc[15:8]});
         exp_flen.push_back(m_n + 2);
         m_n   = 0;
         m_crc = 16'hFFFF;
      end
   endtask

   task automatic push_frame6();
      logic [7:0] f[6];
      f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
      for (int i = 0; i < 6; i++) push_byte(f[i], i == 5);
   endtask

   task automatic push_ascii();
      for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i), i == 8);
   endtask

   task automatic run(input bit rand_rdy, input string name);
      int         cyc;
      bit         prev_stall;
      logic [7:0] prev_d;
      logic       prev_l, exp_rdy;
      logic [8:0] e;
      cyc = 0;
      prev_stall = 0;
      prev_d = 8'h00;
      prev_l = 1'b0;
      while ((stim_d.size() > 0 || exp_d.size() > 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stim_d.size() > 0) begin
            in_valid = 1'b1;
            in_data  = stim_d[0];
            in_last  = stim_l[0];
         end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
         end
         #1;
         if (prev_stall) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, prev_d);
            check_eq("stall_last", out_last, prev_l);
         end
         if (len_err) obs_lenerr++;
         exp_rdy = crc_phase ? (out_valid && out_last && out_ready) : (!out_valid || out_ready);
         check_eq("in_ready", in_ready, exp_rdy);
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
               check_eq("extra_out", exp_d.size(), 1);
            end else begin
               e = exp_d.pop_front();
               check_eq("out_data", out_data, e[7:0]);
               check_eq("out_last", out_last, e[8]);
               if (e[8]) begin
                  check_eq("frame_len", frame_len, exp_flen.pop_front());
                  crc_phase = 0;
                  tail_lo   = prev_out;
                  tail_hi   = out_data;
               end
            end
            prev_out = out_data;
         end
         if (in_valid && in_ready) begin
            in_n++;
            if (stim_l[0] || in_n == 254) begin
               crc_phase = 1;
               in_n      = 0;
            end
            void'(stim_d.pop_front());
            void'(stim_l.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;
      end
      in_valid = 1'b0;
      check_eq({name, "_drain"}, stim_d.size() + exp_d.size(), 0);
      check_eq({name, "_len_err_cnt"}, obs_lenerr, exp_lenerr);
   endtask

   initial begin
      rst = 1'b0;
      in_data = 8'h00;
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_frame_len", frame_len, 0);
      check_eq("rst_len_err", len_err, 0);
      check_eq("rst_in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      push_frame6();
      run(0, "frame6");
      check_eq("frame6_tail_lo", tail_lo, 8'h84);
      check_eq("frame6_tail_hi", tail_hi, 8'h0A);
      check_eq("frame6_len", frame_len, 8);

      push_ascii();
      run(0, "ascii1");
      check_eq("ascii1_tail_lo", tail_lo, 8'h37);
      check_eq("ascii1_tail_hi", tail_hi, 8'h4B);
      push_ascii();
      push_ascii();
      run(0, "ascii_b2b");
      check_eq("ascii2_tail_lo", tail_lo, 8'h37);
      check_eq("ascii2_tail_hi", tail_hi, 8'h4B);

      push_frame6();
      run(1, "frame6_stall");
      check_eq("stall_tail_lo", tail_lo, 8'h84);
      check_eq("stall_tail_hi", tail_hi, 8'h0A);

      for (int i = 0; i < 260; i++) push_byte(8'($urandom), i == 259);
      run(1, "overlong");
      check_eq("overlong_len_err_total", obs_lenerr, 1);
      check_eq("overlong_tail_len", frame_len, 8);

      // Reset in the middle of a frame: partial payload must vanish without a CRC.
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         in_last  = 1'b0;
         #1;
         check_eq("pre_rst_in_ready", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_in_ready", in_ready, 0);
      check_eq("mid_rst_out_last", out_last, 0);
      check_eq("mid_rst_frame_len", frame_len, 0);
      @(negedge clk);
      rst = 1'b1;
      push_frame6();
      run(0, "after_rst");
      check_eq("after_rst_tail_lo", tail_lo, 8'h84);
      check_eq("after_rst_tail_hi", tail_hi, 8'h0A);

      for (int f = 0; f < 6; f++) begin
         int len;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) push_byte(8'($urandom), i == len - 1);
      end
      run(1, "random_frames");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
